// File: rtl/decode_stage_if.sv
// Valid/ready word port between fetch and decode.
// upstream/slave is the consumer side, downstream/master the producer side.
interface skid_buffer_port;
  logic        valid;
  logic [31:0] data;
  logic        ready;

  modport upstream (
    input  valid,
    input  data,
    output ready
  );

  modport downstream (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

  modport master (
    output valid,
    output data,
    input  ready
  );
endinterface

// File: rtl/decode_stage.sv
// RV32E decode stage with a 2-entry output skid buffer.
// Optional DECODE_PERF_COUNT_EN adds decoded/illegal output counters.
module decode_stage (
  input  logic                     clock,
  input  logic                     reset,
  skid_buffer_port.upstream        fetch,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_op,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_rs1,
  output logic [3:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic                     out_funct7b5,
  output logic [31:0]              out_imm,
  output logic                     out_illegal,
`ifdef DECODE_PERF_COUNT_EN
  output logic [31:0]              perf_decoded,
  output logic [31:0]              perf_illegal,
`endif
  output logic [31:0]              out_raw
);

  typedef enum logic [3:0] {
    C_LUI   = 4'd0,
    C_AUIPC = 4'd1,
    C_JAL   = 4'd2,
    C_JALR  = 4'd3,
    C_BR    = 4'd4,
    C_LOAD  = 4'd5,
    C_STORE = 4'd6,
    C_OPIMM = 4'd7,
    C_OP    = 4'd8,
    C_FENCE = 4'd9,
    C_SYS   = 4'd10,
    C_ILL   = 4'd15
  } cls_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] raw;
  } dec_t;

  logic [31:0] w_i;
  logic [6:0]  w_opc;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_i   = fetch.data;
  assign w_opc = w_i[6:0];
  assign w_f7  = w_i[31:25];
  assign w_f3  = w_i[14:12];

  assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
  assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7],
                    w_i[30:25], w_i[11:8], 1'b0};
  assign w_imm_u = {w_i[31:12], 12'b0};
  assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                    w_i[20], w_i[30:21], 1'b0};

  logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
  logic w_is_br, w_is_load, w_is_store, w_is_opimm;
  logic w_is_op, w_is_fence, w_is_sys;

  assign w_is_lui   = (w_opc == 7'h37);
  assign w_is_auipc = (w_opc == 7'h17);
  assign w_is_jal   = (w_opc == 7'h6F);
  assign w_is_jalr  = (w_opc == 7'h67);
  assign w_is_br    = (w_opc == 7'h63);
  assign w_is_load  = (w_opc == 7'h03);
  assign w_is_store = (w_opc == 7'h23);
  assign w_is_opimm = (w_opc == 7'h13);
  assign w_is_op    = (w_opc == 7'h33);
  assign w_is_fence = (w_opc == 7'h0F);
  assign w_is_sys   = (w_opc == 7'h73);

  cls_t        w_cls;
  logic [31:0] w_imm;
  logic        w_urd;
  logic        w_urs1;
  logic        w_urs2;

  always_comb begin
    w_cls  = C_ILL;
    w_imm  = '0;
    w_urd  = 1'b0;
    w_urs1 = 1'b0;
    w_urs2 = 1'b0;
    unique case (1'b1)
      w_is_lui: begin
        w_cls = C_LUI;   w_imm = w_imm_u; w_urd = 1'b1;
      end
      w_is_auipc: begin
        w_cls = C_AUIPC; w_imm = w_imm_u; w_urd = 1'b1;
      end
      w_is_jal: begin
        w_cls = C_JAL;   w_imm = w_imm_j; w_urd = 1'b1;
      end
      w_is_jalr: begin
        w_cls = C_JALR;  w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1;
      end
      w_is_br: begin
        w_cls = C_BR;    w_imm = w_imm_b;
        w_urs1 = 1'b1;   w_urs2 = 1'b1;
      end
      w_is_load: begin
        w_cls = C_LOAD;  w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1;
      end
      w_is_store: begin
        w_cls = C_STORE; w_imm = w_imm_s;
        w_urs1 = 1'b1;   w_urs2 = 1'b1;
      end
      w_is_opimm: begin
        w_cls = C_OPIMM; w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1;
      end
      w_is_op: begin
        w_cls = C_OP;    w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1; w_urs2 = 1'b1;
      end
      w_is_fence: begin
        w_cls = C_FENCE; w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1;
      end
      w_is_sys: begin
        w_cls = C_SYS;   w_imm = w_imm_i;
        w_urd = 1'b1;    w_urs1 = 1'b1;
      end
      default: ;
    endcase
  end

  logic w_bad_reg;
  logic w_bad_op;
  logic w_bad_sh;
  logic w_ill;

  // RV32E has only x0..x15, so bit 4 of any used field is fatal
  assign w_bad_reg = (w_urd  & w_i[11])
                   | (w_urs1 & w_i[19])
                   | (w_urs2 & w_i[24]);

  assign w_bad_op = w_is_op &&
    !((w_f7 == 7'h00) ||
      (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));

  assign w_bad_sh = w_is_opimm &&
    ((w_f3 == 3'd1 && w_f7 != 7'h00) ||
     (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20));

  assign w_ill = (w_i[1:0] != 2'b11) || (w_cls == C_ILL)
              || w_bad_reg || w_bad_op || w_bad_sh;

  dec_t w_dec;

  always_comb begin
    w_dec      = '0;
    w_dec.op   = w_ill ? C_ILL : w_cls;
    w_dec.f3   = w_f3;
    w_dec.f7b5 = w_i[30];
    w_dec.raw  = w_i;
    if (!w_ill) begin
      w_dec.imm = w_imm;
      w_dec.rd  = w_urd  ? w_i[10:7]  : 4'd0;
      w_dec.rs1 = w_urs1 ? w_i[18:15] : 4'd0;
      w_dec.rs2 = w_urs2 ? w_i[23:20] : 4'd0;
    end
  end

  logic r_main_v;
  logic r_skid_v;
  logic r_ready;
  dec_t r_main;
  dec_t r_skid;

  logic w_acc;
  logic w_drain;

  assign w_acc   = fetch.valid && r_ready;
  assign w_drain = r_main_v && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_drain && r_skid_v) begin
      r_main   <= r_skid;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_drain || !r_main_v) begin
      r_main_v <= w_acc;
      if (w_acc) r_main <= w_dec;
      r_ready  <= 1'b1;
    end else if (w_acc) begin
      r_skid   <= w_dec;
      r_skid_v <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      r_ready  <= !r_skid_v;
    end
  end

  assign fetch.ready  = r_ready;
  assign out_valid    = r_main_v;
  assign out_op       = r_main.op;
  assign out_rd       = r_main.rd;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_funct3   = r_main.f3;
  assign out_funct7b5 = r_main.f7b5;
  assign out_imm      = r_main.imm;
  assign out_raw      = r_main.raw;
  assign out_illegal  = (r_main.op == C_ILL);

`ifdef DECODE_PERF_COUNT_EN
  logic [31:0] r_perf_dec;
  logic [31:0] r_perf_ill;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_dec <= '0;
      r_perf_ill <= '0;
    end else if (w_drain) begin
      r_perf_dec <= r_perf_dec + 32'd1;
      if (out_illegal) r_perf_ill <= r_perf_ill + 32'd1;
    end
  end

  assign perf_decoded = r_perf_dec;
  assign perf_illegal = r_perf_ill;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid
// back-pressure, flush and asynchronous reset.
module tb_decode_stage;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_op, out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [31:0] out_imm, out_raw;
  logic        out_illegal;
`ifdef DECODE_PERF_COUNT_EN
  logic [31:0] perf_decoded, perf_illegal;
`endif

  int total = 0;
  int bad   = 0;

  skid_buffer_port fetch_if ();

  decode_stage dut (
    .clock        (clk),
    .reset        (rst_n),
    .fetch        (fetch_if),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal),
`ifdef DECODE_PERF_COUNT_EN
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal),
`endif
    .out_raw      (out_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  op, rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    fetch_if.valid = 1'b0;
    fetch_if.data  = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || fetch_if.ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got v=%b r=%b want v=0 r=0",
               out_valid, fetch_if.ready);
    end
    total++;
    if (out_op !== 4'd0 || out_imm !== 32'd0 || out_raw !== 32'd0) begin
      bad++;
      $display("FAIL reset_fields got op=%h imm=%h raw=%h want 0",
               out_op, out_imm, out_raw);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (fetch_if.ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got %b want 1", fetch_if.ready);
    end
  endtask

  task automatic test_decode();
    vec_t vt[16];
    vt[0]  = '{32'h00500093, 4'd7,  4'd1, 4'd0, 4'd0, 3'd0, 1'b0, 32'h00000005};
    vt[1]  = '{32'hFE208EE3, 4'd4,  4'd0, 4'd1, 4'd2, 3'd0, 1'b1, 32'hFFFFFFFC};
    vt[2]  = '{32'h12345137, 4'd0,  4'd2, 4'd0, 4'd0, 3'd5, 1'b0, 32'h12345000};
    vt[3]  = '{32'h00000833, 4'd15, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 32'h0};
    vt[4]  = '{32'h0080006F, 4'd2,  4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 32'h00000008};
    vt[5]  = '{32'h0020A623, 4'd6,  4'd0, 4'd1, 4'd2, 3'd2, 1'b0, 32'h0000000C};
    vt[6]  = '{32'h402081B3, 4'd8,  4'd3, 4'd1, 4'd2, 3'd0, 1'b1, 32'h00000402};
    vt[7]  = '{32'h402091B3, 4'd15, 4'd0, 4'd0, 4'd0, 3'd1, 1'b1, 32'h0};
    vt[8]  = '{32'h00000001, 4'd15, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 32'h0};
    vt[9]  = '{32'h0000007F, 4'd15, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 32'h0};
    vt[10] = '{32'h4010D093, 4'd7,  4'd1, 4'd1, 4'd0, 3'd5, 1'b1, 32'h00000401};
    vt[11] = '{32'h0210D093, 4'd15, 4'd0, 4'd0, 4'd0, 3'd5, 1'b0, 32'h0};
    vt[12] = '{32'hFF8100E7, 4'd3,  4'd1, 4'd2, 4'd0, 3'd0, 1'b1, 32'hFFFFFFF8};
    vt[13] = '{32'h0000A883, 4'd15, 4'd0, 4'd0, 4'd0, 3'd2, 1'b0, 32'h0};
    vt[14] = '{32'h00001297, 4'd1,  4'd5, 4'd0, 4'd0, 3'd1, 1'b0, 32'h00001000};
    vt[15] = '{32'h00000073, 4'd10, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 32'h0};
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      fetch_if.valid = 1'b1;
      fetch_if.data  = vt[k].w;
      tick();
      fetch_if.valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_raw !== vt[k].w) begin
        bad++;
        $display("FAIL dec%0d_out got v=%b raw=%h want v=1 raw=%h",
                 k, out_valid, out_raw, vt[k].w);
      end
      total++;
      if (out_op !== vt[k].op
          || out_illegal !== (vt[k].op == 4'd15)) begin
        bad++;
        $display("FAIL dec%0d_op got op=%0d ill=%b want op=%0d",
                 k, out_op, out_illegal, vt[k].op);
      end
      total++;
      if (out_rd !== vt[k].rd || out_rs1 !== vt[k].rs1
          || out_rs2 !== vt[k].rs2) begin
        bad++;
        $display("FAIL dec%0d_regs got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, out_rd, out_rs1, out_rs2,
                 vt[k].rd, vt[k].rs1, vt[k].rs2);
      end
      total++;
      if (out_funct3 !== vt[k].f3 || out_funct7b5 !== vt[k].f7) begin
        bad++;
        $display("FAIL dec%0d_funct got f3=%0d f7b5=%b want f3=%0d f7b5=%b",
                 k, out_funct3, out_funct7b5, vt[k].f3, vt[k].f7);
      end
      total++;
      if (out_imm !== vt[k].imm) begin
        bad++;
        $display("FAIL dec%0d_imm got %h want %h", k, out_imm, vt[k].imm);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL dec%0d_drain got v=%b want 0", k, out_valid);
      end
    end
`ifdef DECODE_PERF_COUNT_EN
    total++;
    if (perf_decoded !== 32'd16 || perf_illegal !== 32'd6) begin
      bad++;
      $display("FAIL perf got dec=%0d ill=%0d want 16/6",
               perf_decoded, perf_illegal);
    end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    fetch_if.valid = 1'b1;
    fetch_if.data  = 32'h00100093;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_raw !== 32'h00100093
        || fetch_if.ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got v=%b raw=%h r=%b want 1/00100093/1",
               out_valid, out_raw, fetch_if.ready);
    end
    fetch_if.data = 32'h00200113;
    tick();
    total++;
    if (fetch_if.ready !== 1'b0 || out_raw !== 32'h00100093) begin
      bad++;
      $display("FAIL b2b_skid got r=%b raw=%h want 0/00100093",
               fetch_if.ready, out_raw);
    end
    fetch_if.data = 32'h00300193;
    tick();
    total++;
    if (fetch_if.ready !== 1'b0 || out_valid !== 1'b1
        || out_raw !== 32'h00100093 || out_imm !== 32'd1) begin
      bad++;
      $display("FAIL b2b_hold got r=%b v=%b raw=%h imm=%h want 0/1/00100093/1",
               fetch_if.ready, out_valid, out_raw, out_imm);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_raw !== 32'h00200113 || out_rd !== 4'd2
        || fetch_if.ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got raw=%h rd=%0d r=%b want 00200113/2/1",
               out_raw, out_rd, fetch_if.ready);
    end
    tick();
    fetch_if.valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_raw !== 32'h00300193
        || out_imm !== 32'd3) begin
      bad++;
      $display("FAIL b2b_third got v=%b raw=%h imm=%h want 1/00300193/3",
               out_valid, out_raw, out_imm);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    fetch_if.valid = 1'b1;
    fetch_if.data  = 32'h00100093;
    tick();
    fetch_if.data  = 32'h00200113;
    tick();
    fetch_if.data  = 32'h00300193;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_if.valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || fetch_if.ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_full got v=%b r=%b want 0/1",
               out_valid, fetch_if.ready);
    end
    out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_stale got v=%b raw=%h want v=0",
               out_valid, out_raw);
    end
    fetch_if.valid = 1'b1;
    fetch_if.data  = 32'h00500093;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_if.valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    fetch_if.valid = 1'b1;
    fetch_if.data  = 32'h00100093;
    tick();
    tick();
    fetch_if.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || fetch_if.ready !== 1'b0
        || out_raw !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got v=%b r=%b raw=%h want 0/0/0",
               out_valid, fetch_if.ready, out_raw);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (fetch_if.ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_recover got r=%b v=%b want 1/0",
               fetch_if.ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
